// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared definitions for the bus transfer sequencer.
//   state_e        - FSM state encoding (3-bit)
//   DefaultIdleKey - key value that no mux stage may decode
//   cnt_width()    - settle counter width, never below one bit
package bus_transfer_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDrive  = 3'd1,
        StSettle = 3'd2,
        StLoad   = 3'd3,
        StDone   = 3'd4
    } state_e;

    localparam int unsigned DefaultIdleKey = 0;

    function automatic int unsigned cnt_width(input int unsigned settle);
        int unsigned w;
        w = $clog2(settle + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_transfer_sequencer_equals.sv
// Full-width unsigned equality comparator.
//   a_i, b_i : operands (BUS_SIZE bits)
//   equal_o  : high when a_i == b_i
module bus_transfer_sequencer_equals
    import bus_transfer_sequencer_pkg::*;
#(
    parameter int unsigned BUS_SIZE = 8
) (
    input  logic [BUS_SIZE-1:0] a_i,
    input  logic [BUS_SIZE-1:0] b_i,
    output logic                equal_o
);

    assign equal_o = (a_i == b_i);

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Upstream controller for the keyed mux chain on the internal data bus.
// Accepts one src/dst transfer request, keys the source mux onto the bus, waits
// SETTLE_CYCLES, strobes load_en/load_key for the destination, captures the word.
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake; req_src/req_dst codes
//   bus_key              : key to the mux chain; bus_data: last mux stage output
//   load_key/load_en     : destination strobe
//   done/err             : completion pulse, err marks an illegal (unexecuted) request
//   last_data            : word captured by the last successful transfer
module bus_transfer_sequencer
    import bus_transfer_sequencer_pkg::*;
#(
    parameter int unsigned                DATA_BUS_SIZE = 16,
    parameter int unsigned                KEY_SIZE      = 8,
    parameter logic [KEY_SIZE-1:0]        IDLE_KEY      = KEY_SIZE'(DefaultIdleKey),
    parameter int unsigned                SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [KEY_SIZE-1:0]      req_src,
    input  logic [KEY_SIZE-1:0]      req_dst,
    output logic [KEY_SIZE-1:0]      bus_key,
    input  logic [DATA_BUS_SIZE-1:0] bus_data,
    output logic [KEY_SIZE-1:0]      load_key,
    output logic                     load_en,
    output logic                     done,
    output logic                     err,
    output logic [DATA_BUS_SIZE-1:0] last_data
);

    localparam int unsigned CntW = cnt_width(SETTLE_CYCLES);

    state_e                   state_q, state_d;
    logic [KEY_SIZE-1:0]      src_q, src_d;
    logic [KEY_SIZE-1:0]      dst_q, dst_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [KEY_SIZE-1:0]      bus_key_q, bus_key_d;
    logic [KEY_SIZE-1:0]      load_key_q, load_key_d;
    logic                     load_en_q, load_en_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [DATA_BUS_SIZE-1:0] last_data_q, last_data_d;

    logic src_is_idle;
    logic src_is_dst;
    logic illegal;

    bus_transfer_sequencer_equals #(
        .BUS_SIZE(KEY_SIZE)
    ) u_eq_idle (
        .a_i     (req_src),
        .b_i     (IDLE_KEY),
        .equal_o (src_is_idle)
    );

    bus_transfer_sequencer_equals #(
        .BUS_SIZE(KEY_SIZE)
    ) u_eq_dst (
        .a_i     (req_src),
        .b_i     (req_dst),
        .equal_o (src_is_dst)
    );

    assign illegal = src_is_idle | src_is_dst;

    // Output registers are loaded with the values belonging to the state being
    // entered, so every output except req_ready comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        bus_key_d   = IDLE_KEY;
        load_key_d  = IDLE_KEY;
        load_en_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        last_data_d = last_data_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    src_d = req_src;
                    dst_d = req_dst;
                    if (illegal) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = StDrive;
                        bus_key_d = req_src;
                    end
                end
            end
            StDrive: begin
                bus_key_d = src_q;
                if (SETTLE_CYCLES == 0) begin
                    state_d    = StLoad;
                    load_key_d = dst_q;
                    load_en_d  = 1'b1;
                end else begin
                    state_d = StSettle;
                    cnt_d   = CntW'(SETTLE_CYCLES - 1);
                end
            end
            StSettle: begin
                bus_key_d = src_q;
                if (cnt_q == '0) begin
                    state_d    = StLoad;
                    load_key_d = dst_q;
                    load_en_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StLoad: begin
                state_d     = StDone;
                done_d      = 1'b1;
                last_data_d = bus_data;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            src_q       <= IDLE_KEY;
            dst_q       <= IDLE_KEY;
            cnt_q       <= '0;
            bus_key_q   <= IDLE_KEY;
            load_key_q  <= IDLE_KEY;
            load_en_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            bus_key_q   <= bus_key_d;
            load_key_q  <= load_key_d;
            load_en_q   <= load_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_data_q <= last_data_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign bus_key   = bus_key_q;
    assign load_key  = load_key_q;
    assign load_en   = load_en_q;
    assign done      = done_q;
    assign err       = err_q;
    assign last_data = last_data_q;

endmodule
